// File: rtl/spectrum_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spectrum_uart_tx                                                |
// | Function : streams one FFT magnitude frame (sync, bins, checksum) as 8N1    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module spectrum_uart_tx #(
  parameter int unsigned ClkFrequency = 24000000,
  parameter int unsigned Baud         = 57600,
  parameter int unsigned NUM_BINS     = 512,
  parameter int unsigned ADDR_W       = 9,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic              cclk,
  input  logic              reset,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_data,
  output logic              TxD,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned       DIV       = ClkFrequency / Baud;
  localparam int unsigned       CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_BIN  = ADDR_W'(NUM_BINS - 1);
  localparam logic [3:0]        STOP_BIT  = 4'd9;

  typedef enum logic [2:0] {IDLE, SEND_SYNC, SEND_BIN, SEND_CSUM, DONE} state_e;

  state_e            state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        hold_q, hold_d;
  logic [7:0]        csum_q, csum_d;
  logic [3:0]        bit_q, bit_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [ADDR_W-1:0] bin_q, bin_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              txd_q, txd_d;
  logic              bit_end;
  logic              byte_end;
  logic [ADDR_W-1:0] addr_next;

  assign bit_end   = (baud_q == BAUD_LAST);
  assign byte_end  = bit_end && (bit_q == STOP_BIT);
  // The prefetch address saturates at the last bin so it never wraps mid-frame.
  assign addr_next = (addr_q == LAST_BIN) ? addr_q : addr_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    csum_d  = csum_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    bin_d   = bin_q;
    addr_d  = addr_q;
    txd_d   = txd_q;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = SEND_SYNC;
          shift_d = SYNC_BYTE;
          txd_d   = 1'b0;
          addr_d  = '0;
          csum_d  = '0;
          bin_d   = '0;
          bit_d   = '0;
          baud_d  = '0;
        end
      end
      SEND_SYNC, SEND_BIN, SEND_CSUM: begin
        baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
        // RAM data for the address set at the start bit is stable two edges later.
        if (bit_q == 4'd0 && baud_q == CNT_W'(1)) hold_d = ram_data;
        if (byte_end) begin
          bit_d = '0;
          txd_d = 1'b0;
          if (state_q == SEND_SYNC) begin
            state_d = SEND_BIN;
            shift_d = hold_q;
            csum_d  = csum_q + hold_q;
            addr_d  = addr_next;
          end else if (state_q == SEND_BIN) begin
            if (bin_q == LAST_BIN) begin
              state_d = SEND_CSUM;
              shift_d = csum_q;
            end else begin
              bin_d   = bin_q + ADDR_W'(1);
              shift_d = hold_q;
              csum_d  = csum_q + hold_q;
              addr_d  = addr_next;
            end
          end else begin
            state_d = DONE;
            txd_d   = 1'b1;
            addr_d  = '0;
          end
        end else if (bit_end) begin
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd8) begin
            txd_d = 1'b1;
          end else begin
            txd_d   = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        addr_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cclk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      hold_q  <= '0;
      csum_q  <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      bin_q   <= '0;
      addr_q  <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      csum_q  <= csum_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      bin_q   <= bin_d;
      addr_q  <= addr_d;
      txd_q   <= txd_d;
    end
  end

  assign ram_addr   = addr_q;
  assign TxD        = txd_q;
  assign busy       = (state_q == SEND_SYNC) || (state_q == SEND_BIN) || (state_q == SEND_CSUM);
  assign frame_done = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_spectrum_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_spectrum_uart_tx                                             |
// | Function : randomized frame checks against a byte-stream reference model    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_spectrum_uart_tx;

  localparam int CLK_HZ    = 1600;
  localparam int BAUD      = 100;
  localparam int DIV       = 16;
  localparam int NB        = 64;
  localparam int AW        = 9;
  localparam int BYTE_CYC  = 10 * DIV;
  localparam int FRAME_CYC = (NB + 2) * BYTE_CYC;

  logic          cclk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_data;
  logic          TxD;
  logic          busy;
  logic          frame_done;
  logic [7:0]    mem [512];
  int            checks = 0;
  int            failures = 0;

  spectrum_uart_tx #(
    .ClkFrequency(CLK_HZ),
    .Baud        (BAUD),
    .NUM_BINS    (NB),
    .ADDR_W      (AW),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .cclk       (cclk),
    .reset      (reset),
    .frame_start(frame_start),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .TxD        (TxD),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 cclk = ~cclk;

  always @(posedge cclk) ram_data <= mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge cclk);
    #1;
  endtask

  // Expected line behaviour derived from the byte sequence alone: byte j
  // occupies cycles [j*BYTE_CYC, (j+1)*BYTE_CYC), bit slot b = start/data/stop.
  task automatic run_frame(input int mid_pulse);
    logic [7:0] exp_b[$];
    logic [7:0] sum;
    logic [7:0] sync;
    logic [9:0] word;
    logic       exp_bit;
    int         done_cnt;
    int         done_at;
    int         busy_last;
    int         addr_bad;
    sync = 8'hA5;
    sum  = 8'h00;
    word = '0;
    done_cnt = 0; done_at = -1; busy_last = -1; addr_bad = 0;
    exp_b.push_back(sync);
    for (int i = 0; i < NB; i++) begin
      exp_b.push_back(mem[i]);
      sum = sum + mem[i];
    end
    exp_b.push_back(sum);

    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int k = 0; k < FRAME_CYC + 20; k++) begin
      int b;
      b = (k % BYTE_CYC) / DIV;
      if (k < BYTE_CYC) begin
        exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : sync[b-1];
        check("sync_bit", {31'd0, TxD}, {31'd0, exp_bit});
      end
      if (k < FRAME_CYC && (k % DIV) == DIV / 2) begin
        word[b] = TxD;
        if (b == 9) check("byte", {22'd0, word}, {22'd0, 1'b1, exp_b[k / BYTE_CYC], 1'b0});
      end
      if (frame_done) begin
        done_cnt++;
        done_at = k;
      end
      if (busy) busy_last = k;
      if (ram_addr >= AW'(NB)) addr_bad++;
      if (k == mid_pulse) frame_start = 1'b1;
      else if (k == mid_pulse + 1) frame_start = 1'b0;
      step();
    end
    check("done_count", done_cnt, 1);
    check("done_cycle", done_at, FRAME_CYC);
    check("busy_last", busy_last, FRAME_CYC - 1);
    check("addr_range", addr_bad, 0);
    check("post_idle", {21'd0, TxD, busy, frame_done, ram_addr}, {21'd0, 1'b1, 1'b0, 1'b0, 9'd0});
  endtask

  task automatic run_reset(input int rst_cycle);
    int bad;
    bad = 0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    repeat (rst_cycle) step();
    #2 reset = 1'b1;
    #1;
    check("rst_txd", {31'd0, TxD}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_addr", {23'd0, ram_addr}, 32'd0);
    step();
    reset = 1'b0;
    repeat (BYTE_CYC) begin
      if (frame_done || busy || !TxD || ram_addr != '0) bad++;
      step();
    end
    check("post_reset_idle", bad, 0);
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 512; i++) mem[i] = 8'(i);
    reset = 1'b1;
    frame_start = 1'b0;
    repeat (3) step();
    check("reset_txd", {31'd0, TxD}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, frame_done}, 32'd0);
    check("reset_addr", {23'd0, ram_addr}, 32'd0);
    reset = 1'b0;
    bad = 0;
    repeat (1000) begin
      if (!TxD || busy || frame_done || ram_addr != '0) bad++;
      step();
    end
    check("idle_bad_cycles", bad, 0);

    run_frame(-10);
    repeat (3) step();

    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[5] = 8'h37;
    run_frame(-10);
    repeat (3) step();

    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    run_frame(int'($urandom_range(FRAME_CYC - 200, 200)));
    repeat (3) step();

    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    run_reset(int'($urandom_range(5000, 1000)));
    run_frame(-10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
